// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-requester SRAM port arbiter.
// Command fields are sized from the package widths; the top may override them by parameter.
package sram_arb_pkg;

  localparam int SRAM_ADDR_WIDTH = 11;
  localparam int SRAM_DATA_WIDTH = 32;
  localparam int SRAM_BE_WIDTH   = SRAM_DATA_WIDTH / 8;

  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } arb_last_e;

  typedef struct packed {
    logic [SRAM_ADDR_WIDTH-1:0] addr;
    logic                       we;
    logic [SRAM_BE_WIDTH-1:0]   be;
    logic [SRAM_DATA_WIDTH-1:0] wdata;
  } sram_req_t;

  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, registered last-winner pointer.
//   state | meaning
//   LAST0 | requester 0 won most recently; requester 1 wins the next contention
//   LAST1 | requester 1 won most recently (reset); requester 0 wins the next contention
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o
);

  arb_last_e last_q, last_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_q <= LAST1;
    else       last_q <= last_d;
  end

  // Grant is held off while reset is asserted so nothing reaches the SRAM.
  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    if (!rst_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (last_q == LAST1) ? idx_to_onehot(1'b0) : idx_to_onehot(1'b1);
        default: gnt_o = 2'b00;
      endcase
    end
    if (gnt_o[0])      last_d = LAST0;
    else if (gnt_o[1]) last_d = LAST1;
  end

  assign gnt_idx_o = gnt_o[1];

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between CPU data (0) and loader/DMA (1) with no wait states.
// Command mux is combinational on the grant; responses are routed one cycle later.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [1:0]                  req_i,
  output logic [1:0]                  gnt_o,
  input  logic [1:0][ADDR_WIDTH-1:0]  addr_i,
  input  logic [1:0]                  we_i,
  input  logic [1:0][DATA_WIDTH/8-1:0] be_i,
  input  logic [1:0][DATA_WIDTH-1:0]  wdata_i,
  output logic [1:0]                  rvalid_o,
  output logic [1:0][DATA_WIDTH-1:0]  rdata_o,
  output logic                        ram_en_o,
  output logic                        ram_we_o,
  output logic [ADDR_WIDTH-1:0]       ram_addr_o,
  output logic [DATA_WIDTH/8-1:0]     ram_be_o,
  output logic [DATA_WIDTH-1:0]       ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]       ram_rdata_i
);

  logic [1:0] gnt;
  logic       gnt_idx;
  logic       any_gnt;

  logic       rsp_valid_q;
  logic       rsp_idx_q;
  logic       rsp_read_q;

  rr_arb2 u_rr_arb2 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign gnt_o   = gnt;
  assign any_gnt = |gnt;

  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    if (any_gnt) begin
      ram_en_o    = 1'b1;
      ram_we_o    = we_i[gnt_idx];
      ram_addr_o  = addr_i[gnt_idx];
      ram_be_o    = be_i[gnt_idx];
      ram_wdata_o = wdata_i[gnt_idx];
    end
  end

  // Only one response is ever in flight, so a single routing register suffices.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= 1'b0;
      rsp_read_q  <= 1'b0;
    end else begin
      rsp_valid_q <= any_gnt;
      rsp_idx_q   <= gnt_idx;
      rsp_read_q  <= any_gnt & ~we_i[gnt_idx];
    end
  end

  always_comb begin
    rvalid_o = 2'b00;
    rdata_o  = '0;
    if (rsp_valid_q) begin
      rvalid_o[rsp_idx_q] = 1'b1;
      if (rsp_read_q) rdata_o[rsp_idx_q] = ram_rdata_i;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: vector table plus reset/contention/idle sequences.
module tb_sram_port_arbiter;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  localparam logic [AW-1:0] ADDR0 = 11'h010;
  localparam logic [AW-1:0] ADDR1 = 11'h2A5;
  localparam logic [BW-1:0] BE0   = 4'hF;
  localparam logic [BW-1:0] BE1   = 4'h3;
  localparam logic [DW-1:0] WD0   = 32'h1234_5678;
  localparam logic [DW-1:0] WD1   = 32'hDEAD_BEEF;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [1:0]           req = 2'b00;
  logic [1:0]           gnt;
  logic [1:0][AW-1:0]   addr;
  logic [1:0]           we = 2'b00;
  logic [1:0][BW-1:0]   be;
  logic [1:0][DW-1:0]   wdata;
  logic [1:0]           rvalid;
  logic [1:0][DW-1:0]   rdata;
  logic                 ram_en;
  logic                 ram_we;
  logic [AW-1:0]        ram_addr;
  logic [BW-1:0]        ram_be;
  logic [DW-1:0]        ram_wdata;
  logic [DW-1:0]        ram_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .gnt_o       (gnt),
    .addr_i      (addr),
    .we_i        (we),
    .be_i        (be),
    .wdata_i     (wdata),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .ram_en_o    (ram_en),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_be_o    (ram_be),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  typedef struct {
    logic [1:0]    req;
    logic [1:0]    we;
    logic [1:0]    exp_gnt;
    logic [1:0]    exp_rvalid;
    logic [DW-1:0] exp_rd0;
    logic [DW-1:0] exp_rd1;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge and check before the next rising edge.
  task automatic cycle(input string tag, input logic [1:0] r, input logic [1:0] w,
                       input logic [DW-1:0] rd_in, input logic [1:0] exp_gnt,
                       input logic [1:0] exp_rvalid, input logic [DW-1:0] exp_rd0,
                       input logic [DW-1:0] exp_rd1);
    logic          e_en;
    logic          idx;
    @(negedge clk);
    req       = r;
    we        = w;
    ram_rdata = rd_in;
    #2;
    e_en = |exp_gnt;
    idx  = exp_gnt[1];
    chk({tag, " gnt"},    {62'd0, gnt},    {62'd0, exp_gnt});
    chk({tag, " ram_en"}, {63'd0, ram_en}, {63'd0, e_en});
    chk({tag, " ram_we"}, {63'd0, ram_we}, {63'd0, e_en & w[idx]});
    chk({tag, " ram_addr"}, {53'd0, ram_addr}, e_en ? {53'd0, (idx ? ADDR1 : ADDR0)} : 64'd0);
    chk({tag, " ram_be"}, {60'd0, ram_be}, e_en ? {60'd0, (idx ? BE1 : BE0)} : 64'd0);
    chk({tag, " ram_wdata"}, {32'd0, ram_wdata}, e_en ? {32'd0, (idx ? WD1 : WD0)} : 64'd0);
    chk({tag, " rvalid"}, {62'd0, rvalid}, {62'd0, exp_rvalid});
    chk({tag, " rdata0"}, {32'd0, rdata[0]}, {32'd0, exp_rd0});
    chk({tag, " rdata1"}, {32'd0, rdata[1]}, {32'd0, exp_rd1});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 2'b00;
    we  = 2'b00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    addr  = {ADDR1, ADDR0};
    be    = {BE1, BE0};
    wdata = {WD1, WD0};

    //            req    we     gnt    rvalid rd0            rd1
    vecs[0]  = '{2'b01, 2'b00, 2'b01, 2'b00, '0,            '0};
    vecs[1]  = '{2'b00, 2'b00, 2'b00, 2'b01, 32'hC0DE0001, '0};
    vecs[2]  = '{2'b11, 2'b00, 2'b10, 2'b00, '0,            '0};
    vecs[3]  = '{2'b11, 2'b00, 2'b01, 2'b10, '0,            32'hC0DE0003};
    vecs[4]  = '{2'b11, 2'b01, 2'b10, 2'b01, 32'hC0DE0004, '0};
    vecs[5]  = '{2'b10, 2'b10, 2'b10, 2'b10, '0,            32'hC0DE0005};
    vecs[6]  = '{2'b00, 2'b00, 2'b00, 2'b10, '0,            '0};
    vecs[7]  = '{2'b00, 2'b00, 2'b00, 2'b00, '0,            '0};
    vecs[8]  = '{2'b00, 2'b00, 2'b00, 2'b00, '0,            '0};
    vecs[9]  = '{2'b11, 2'b00, 2'b01, 2'b00, '0,            '0};
    vecs[10] = '{2'b01, 2'b01, 2'b01, 2'b01, 32'hC0DE000A, '0};
    vecs[11] = '{2'b00, 2'b00, 2'b00, 2'b01, '0,            '0};

    // Reset values, with requests pending that must not be granted.
    cycle("rst", 2'b11, 2'b00, 32'h1111_1111, 2'b00, 2'b00, '0, '0);
    cycle("rst2", 2'b11, 2'b01, 32'h2222_2222, 2'b00, 2'b00, '0, '0);

    // Contention straight out of reset: 0,1,0,1 with responses one cycle behind.
    @(negedge clk);
    rst = 1'b0;
    req = 2'b11;
    we  = 2'b00;
    #2;
    chk("cont0 gnt", {62'd0, gnt}, 64'd1);
    chk("cont0 rvalid", {62'd0, rvalid}, 64'd0);
    cycle("cont1", 2'b11, 2'b00, 32'hA000_0001, 2'b10, 2'b01, 32'hA000_0001, '0);
    cycle("cont2", 2'b11, 2'b00, 32'hA000_0002, 2'b01, 2'b10, '0, 32'hA000_0002);
    cycle("cont3", 2'b11, 2'b00, 32'hA000_0003, 2'b10, 2'b01, 32'hA000_0003, '0);
    cycle("cont4", 2'b00, 2'b00, 32'hA000_0004, 2'b00, 2'b10, '0, 32'hA000_0004);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle($sformatf("vec%0d", i), vecs[i].req, vecs[i].we, 32'hC0DE0000 + 32'(i),
            vecs[i].exp_gnt, vecs[i].exp_rvalid, vecs[i].exp_rd0, vecs[i].exp_rd1);
    end

    // Reset with a read response pending: response dropped, pointer back to LAST1.
    do_reset();
    cycle("mid0", 2'b01, 2'b00, 32'hB000_0000, 2'b01, 2'b00, '0, '0);
    cycle("mid1", 2'b01, 2'b00, 32'hB000_0001, 2'b01, 2'b01, 32'hB000_0001, '0);
    #1;
    rst = 1'b1;
    #1;
    chk("mid rst rvalid", {62'd0, rvalid}, 64'd0);
    chk("mid rst gnt", {62'd0, gnt}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    req = 2'b00;
    #2;
    chk("mid post rvalid", {62'd0, rvalid}, 64'd0);
    cycle("mid2", 2'b11, 2'b00, 32'hB000_0002, 2'b01, 2'b00, '0, '0);
    cycle("mid3", 2'b00, 2'b00, 32'hB000_0003, 2'b00, 2'b01, 32'hB000_0003, '0);

    for (int i = 0; i < 10; i++) begin
      cycle($sformatf("idle%0d", i), 2'b00, 2'b00, 32'hFFFF_FFFF, 2'b00, 2'b00, '0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, SHALL set the word-address width of the SRAM port.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the data width; byte enables SHALL be DATA_WIDTH/8 bits wide.
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-high.
REQ-004 clk_i  input  1  sole clock, rising-edge.
REQ-005 rst_i  input  1  asynchronous active-high reset.
REQ-006 req_i  input  [1:0]  per-requester access request, with 0 = CPU data and 1 = loader/DMA.
REQ-007 gnt_o  output  [1:0]  per-requester grant, one-hot or zero.
REQ-008 addr_i  input  [1:0][ADDR_WIDTH-1:0]  per-requester word address.
REQ-009 we_i  input  [1:0]  per-requester write enable.
REQ-010 be_i  input  [1:0][DATA_WIDTH/8-1:0]  per-requester byte enables.
REQ-011 wdata_i  input  [1:0][DATA_WIDTH-1:0]  per-requester write data.
REQ-012 rvalid_o  output  [1:0]  per-requester response valid.
REQ-013 rdata_o  output  [1:0][DATA_WIDTH-1:0]  per-requester read data.
REQ-014 ram_en_o, ram_we_o  output  1 each  SRAM enable and write enable, active-high.
REQ-015 ram_addr_o, ram_be_o, ram_wdata_o  output  ADDR_WIDTH, DATA_WIDTH/8, DATA_WIDTH  SRAM command fields.
REQ-016 ram_rdata_i  input  DATA_WIDTH  SRAM read data, valid one cycle after an enabled read.

Function
REQ-017 Grant SHALL be combinational in the request cycle, with gnt_o[n] = req_i[n] AND selected(n); no wait states when uncontested.
REQ-018 With a single active request, that requester SHALL be granted.
REQ-019 Contention: the requester not granted most recently SHALL win (round robin), with pointer last_q in {LAST0, LAST1}.
REQ-020 last_q SHALL update only in cycles with a grant, taking the granted index; it SHALL hold in idle cycles.
REQ-021 In a grant cycle, ram_en_o SHALL be 1 and ram_addr/we/be/wdata SHALL equal the granted requester's inputs.
REQ-022 With no grant, ram_en_o and ram_we_o SHALL be 0 and the other ram_* outputs SHALL be 0.
REQ-023 Exactly one cycle after each grant, rvalid_o[granted] SHALL pulse for one cycle, for reads and writes alike.
REQ-024 rdata_o[n] SHALL equal ram_rdata_i when rvalid_o[n] is high after a read, and 0 otherwise (including write responses).
REQ-025 Back-to-back grants SHALL be supported, giving a throughput of one access per cycle with alternating winners under permanent contention.
REQ-026 A response and a new grant in the same cycle SHALL be independent; the response routing register SHALL hold the previous granted index and read-flag.
REQ-027 Requesters SHALL NOT see rvalid without a prior grant; at most one response SHALL be outstanding per cycle.

Reset
REQ-028 While rst_i is high: last_q = LAST1 (so requester 0 wins the first contention), rvalid_o = 0, response registers cleared, gnt_o = 0, ram_en_o = 0.
REQ-029 Reset asserted with a response pending SHALL drop that response, with no rvalid after deassertion.
REQ-030 The first grant SHALL be possible in the first clock edge cycle after rst_i deasserts.

Structure
REQ-031 Package sram_arb_pkg SHALL hold typedef arb_last_e {LAST0, LAST1} and struct sram_req_t {addr, we, be, wdata}, parameterised via package constants SRAM_ADDR_WIDTH=11 and SRAM_DATA_WIDTH=32.
REQ-032 A single sub-module, rr_arb2 (2-input round-robin grant plus last_q register), SHALL be instantiated; muxing and response routing SHALL reside in the top.

Verification
REQ-033 Single read: req_i=01, addr 0x010 -> gnt_o=01 in the same cycle, ram_en=1, ram_addr=0x010; next cycle rvalid_o=01, rdata_o[0]=ram_rdata_i.
REQ-034 Contention after reset: req_i=11 for 4 cycles -> grants 0,1,0,1; rvalid follows one cycle later in the same order.
REQ-035 Write: req 1 we=1, be=0011, wdata 0xDEADBEEF -> ram_we=1, ram_be=0011; next cycle rvalid_o=10 with rdata_o[1]=0.
REQ-036 Idle between requests: grant 1, then 2 idle cycles, then req_i=11 -> requester 0 wins because the pointer held LAST1.
REQ-037 Reset mid-op: grant read to requester 0, assert rst_i before the next edge -> no rvalid, and last_q returns to LAST1.
REQ-038 Idle: req_i=00 for 10 cycles -> ram_en_o=0, gnt_o=0 and rvalid_o=0 throughout.
